// File: rtl/dht11_reader.sv
// DHT11 single-wire transaction engine: start condition, response timing,
// 40-bit capture measured in microsecond strobes, checksum verification.
module dht11_reader #(
    parameter int START_LOW_US  = 18000,
    parameter int TIMEOUT_US    = 200,
    parameter int BIT_THRESH_US = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_1m,
    input  logic       start,
    input  logic       dq_in,
    output logic       dq_oe,
    output logic       busy,
    output logic       done,
    output logic       valid,
    output logic [1:0] err,
    output logic [7:0] hum_int,
    output logic [7:0] hum_dec,
    output logic [7:0] temp_int,
    output logic [7:0] temp_dec
);

    typedef enum logic [2:0] {
        S_IDLE, S_START_LOW, S_RELEASE_WAIT, S_RESP_LOW,
        S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_CHECK
    } state_t;

    localparam logic [15:0] START_C  = 16'(START_LOW_US);
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT_US);
    localparam logic [15:0] THRESH_C = 16'(BIT_THRESH_US);

    state_t      state_q;
    logic        clk_1m_q;
    logic        dq_s1_q, dq_s2_q, dq_s3_q;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  idx_q;
    logic [39:0] shift_q;
    logic        dq_oe_q, busy_q, done_q, valid_q;
    logic [1:0]  err_q;
    logic [7:0]  hum_int_q, hum_dec_q, temp_int_q, temp_dec_q;

    logic       us, dq_rise, dq_fall, timeout, bit_val;
    logic [7:0] sum;

    assign us      = clk_1m & ~clk_1m_q;
    assign dq_rise = dq_s2_q & ~dq_s3_q;
    assign dq_fall = ~dq_s2_q & dq_s3_q;
    assign cnt_d   = (us && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    assign timeout = cnt_q > TIMEOUT_C;
    assign bit_val = cnt_q > THRESH_C;
    assign sum     = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            clk_1m_q   <= 1'b0;
            // Synchronizer idles at the pulled-up level so reset never fakes an edge
            dq_s1_q    <= 1'b1;
            dq_s2_q    <= 1'b1;
            dq_s3_q    <= 1'b1;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            dq_oe_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 2'd0;
            hum_int_q  <= '0;
            hum_dec_q  <= '0;
            temp_int_q <= '0;
            temp_dec_q <= '0;
        end else begin
            clk_1m_q <= clk_1m;
            dq_s1_q  <= dq_in;
            dq_s2_q  <= dq_s1_q;
            dq_s3_q  <= dq_s2_q;
            done_q   <= 1'b0;
            cnt_q    <= cnt_d;
            case (state_q)
                S_IDLE: if (start) begin
                    state_q <= S_START_LOW;
                    busy_q  <= 1'b1;
                    dq_oe_q <= 1'b1;
                    cnt_q   <= '0;
                end
                S_START_LOW: if (cnt_q >= START_C) begin
                    state_q <= S_RELEASE_WAIT;
                    dq_oe_q <= 1'b0;
                    cnt_q   <= '0;
                end
                S_RELEASE_WAIT, S_RESP_LOW, S_RESP_HIGH: begin
                    if ((state_q == S_RELEASE_WAIT && dq_fall) ||
                        (state_q == S_RESP_LOW && dq_rise) ||
                        (state_q == S_RESP_HIGH && dq_fall)) begin
                        state_q <= (state_q == S_RELEASE_WAIT) ? S_RESP_LOW :
                                   (state_q == S_RESP_LOW)     ? S_RESP_HIGH : S_BIT_LOW;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                    end else if (timeout) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 2'd1;
                    end
                end
                S_BIT_LOW: begin
                    if (dq_rise) begin
                        state_q <= S_BIT_HIGH;
                        cnt_q   <= '0;
                    end else if (timeout) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 2'd2;
                    end
                end
                S_BIT_HIGH: begin
                    if (dq_fall) begin
                        shift_q <= {shift_q[38:0], bit_val};
                        state_q <= (idx_q == 6'd39) ? S_CHECK : S_BIT_LOW;
                        idx_q   <= idx_q + 6'd1;
                        cnt_q   <= '0;
                    end else if (timeout) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 2'd2;
                    end
                end
                S_CHECK: begin
                    if (sum == shift_q[7:0]) begin
                        hum_int_q  <= shift_q[39:32];
                        hum_dec_q  <= shift_q[31:24];
                        temp_int_q <= shift_q[23:16];
                        temp_dec_q <= shift_q[15:8];
                        valid_q    <= 1'b1;
                        err_q      <= 2'd0;
                    end else begin
                        err_q <= 2'd3;
                    end
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    cnt_q   <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dq_oe    = dq_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign valid    = valid_q;
    assign err      = err_q;
    assign hum_int  = hum_int_q;
    assign hum_dec  = hum_dec_q;
    assign temp_int = temp_int_q;
    assign temp_dec = temp_dec_q;

endmodule

// File: tb/tb_dht11_reader.sv
// Bench for dht11_reader: a behavioural DHT11 on the line, a table of frames
// with expected results, plus reset and abuse sequences.
module tb_dht11_reader;
    localparam int S_US  = 100;
    localparam int TO_US = 200;

    logic       clk = 1'b0, reset = 1'b1, clk_1m = 1'b0, start = 1'b0, sens_low = 1'b0;
    logic       dq_in, dq_oe, busy, done, valid;
    logic [1:0] err;
    logic [7:0] hum_int, hum_dec, temp_int, temp_dec;

    // Open-drain line with pull-up: low if host or sensor drives it
    assign dq_in = ~(dq_oe | sens_low);

    dht11_reader #(.START_LOW_US(S_US), .TIMEOUT_US(TO_US), .BIT_THRESH_US(40)) dut (
        .clk(clk), .reset(reset), .clk_1m(clk_1m), .start(start), .dq_in(dq_in),
        .dq_oe(dq_oe), .busy(busy), .done(done), .valid(valid), .err(err),
        .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec));

    // One "microsecond" is two clk periods here to keep the run short
    always #5 clk = ~clk;
    initial forever begin @(negedge clk); clk_1m = ~clk_1m; end

    int checks = 0, errors = 0, done_cnt = 0, oe_cycles = 0, cyc = 0;
    int rel_cyc = 0, done_cyc = 0;
    logic [1:0]  cap_err;
    logic        cap_valid, cap_busy;
    logic [31:0] cap_data;

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (dq_oe) oe_cycles++;
    end

    typedef struct {
        logic [39:0] frame;
        int          mode;      // 0 normal, 1 silent, 2 stall, 4 double start
        int          stop_bit;
        logic [1:0]  e_err;
        logic        e_valid;
        logic [31:0] e_data;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic us_wait(input int n);
        repeat (2 * n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic sensor(input logic [39:0] f, input int mode, input int stop_bit);
        int guard = 0;
        if (mode == 4) begin us_wait(20); pulse_start(); end
        while (dq_oe && guard < 4 * S_US + 100) begin @(negedge clk); guard++; end
        if (dq_oe) begin check("host release", dq_oe, 0); return; end
        rel_cyc = cyc;
        if (mode == 1) return;
        us_wait(30); sens_low = 1'b1; us_wait(80); sens_low = 1'b0; us_wait(80);
        for (int i = 0; i < 40; i++) begin
            sens_low = 1'b1; us_wait(50); sens_low = 1'b0;
            if (i == stop_bit) begin
                if (mode == 3) begin
                    us_wait(10);
                    reset = 1'b1;
                    @(negedge clk);
                    check("reset busy", busy, 0);
                    check("reset dq_oe", dq_oe, 0);
                    check("reset done", done, 0);
                    reset = 1'b0;
                end
                return;
            end
            us_wait(f[39-i] ? 70 : 27);
        end
        sens_low = 1'b1; us_wait(50); sens_low = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic got);
        got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                cap_err = err; cap_valid = valid; cap_busy = busy;
                cap_data = {hum_int, hum_dec, temp_int, temp_dec};
                done_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int   cnt0;
        logic got;
        cnt0 = done_cnt;
        oe_cycles = 0;
        pulse_start();
        check($sformatf("v%0d busy after start", k), busy, 1);
        check($sformatf("v%0d dq_oe after start", k), dq_oe, 1);
        fork
            sensor(v.frame, v.mode, v.stop_bit);
            wait_done(30000, got);
        join
        check($sformatf("v%0d done seen", k), got, 1);
        check($sformatf("v%0d err", k), cap_err, v.e_err);
        check($sformatf("v%0d valid", k), cap_valid, v.e_valid);
        check($sformatf("v%0d data", k), cap_data, v.e_data);
        check($sformatf("v%0d busy at done", k), cap_busy, 0);
        check_range($sformatf("v%0d dq_oe low cycles", k), oe_cycles, 2 * S_US - 2, 2 * S_US + 3);
        if (v.mode == 1)
            check_range("no-response timeout cycles", done_cyc - rel_cyc, 2 * TO_US - 3, 2 * TO_US + 10);
        repeat (100) @(negedge clk);
        check($sformatf("v%0d single done", k), done_cnt - cnt0, 1);
    endtask

    initial begin
        vec_t rv;
        int   cnt0;
        vecs[0] = '{40'h2D00170044, 0, 99, 2'd0, 1'b1, 32'h2D001700};
        vecs[1] = '{40'h2D00170045, 0, 99, 2'd3, 1'b1, 32'h2D001700};
        vecs[2] = '{40'h0000000000, 1, 99, 2'd1, 1'b1, 32'h2D001700};
        vecs[3] = '{40'h3A0519025A, 2, 17, 2'd2, 1'b1, 32'h2D001700};
        vecs[4] = '{40'h3A0519025A, 0, 99, 2'd0, 1'b1, 32'h3A051902};
        vecs[5] = '{40'hC86450108C, 0, 99, 2'd0, 1'b1, 32'hC8645010};
        vecs[6] = '{40'h2D00170044, 4, 99, 2'd0, 1'b1, 32'h2D001700};

        // Reset held 3 cycles, with a start request colliding with it
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            @(negedge clk);
            check("dq_oe during reset", dq_oe, 0);
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset valid", valid, 0);
        check("reset err", err, 0);
        check("reset data", {hum_int, hum_dec, temp_int, temp_dec}, 0);
        repeat (10) @(negedge clk);

        for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

        // Reset in the high phase of bit 5: no done afterwards, outputs cleared
        cnt0 = done_cnt;
        pulse_start();
        sensor(40'h2D00170044, 3, 5);
        repeat (600) @(negedge clk);
        check("no done after reset", done_cnt - cnt0, 0);
        check("busy after reset", busy, 0);
        check("valid after reset", valid, 0);

        rv = '{40'hC86450108C, 0, 99, 2'd0, 1'b1, 32'hC8645010};
        run_vec(7, rv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
